// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder cache-refill/store responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 15;
    localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/mem_array.sv
// Word-organised backing store: byte-enabled synchronous write, combinational read, no reset.
module mem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [IDX_W-1:0]        i_widx,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [IDX_W-1:0]        i_ridx,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
                if (i_be[b]) begin
                    r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for a cache: one request in flight, IDLE/WAIT/RESP FSM.
// Optional performance counters are enabled with `define MEM_RESPONDER_PERF_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_write
`ifdef MEM_RESPONDER_PERF_EN
    ,
    output logic [31:0]           perf_reads,
    output logic [31:0]           perf_writes,
    output logic [31:0]           perf_stall_cycles
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  r_live;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_write;
    logic                  w_accept;
    logic                  w_rsp_hs;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    logic                  w_unused_addr;

    // Byte offset and bits above the word index are don't-care: addresses alias modulo the array size.
    assign w_idx         = req_addr[IDX_W+1:2];
    assign w_unused_addr = ^{req_addr[ADDR_WIDTH-1:IDX_W+2], req_addr[1:0]};

    // r_live keeps req_ready low during reset and rises on the first edge after release.
    assign req_ready = r_live && (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = (r_state == RESP);
    assign w_rsp_hs  = rsp_valid && rsp_ready;
    assign rsp_rdata = r_rdata;
    assign rsp_write = r_write;

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_WIDTH  (DATA_WIDTH),
        .IDX_W       (IDX_W)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_accept && req_write),
        .i_be    (req_be),
        .i_widx  (w_idx),
        .i_wdata (req_wdata),
        .i_ridx  (w_idx),
        .o_rdata (w_mem_rdata)
    );

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next     = WAIT;
                    w_cnt_next = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (w_rsp_hs) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_live  <= 1'b0;
            r_rdata <= '0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_rdata <= req_write ? '0 : w_mem_rdata;
                r_write <= req_write;
            end
        end
    end

`ifdef MEM_RESPONDER_PERF_EN
    logic [31:0] r_perf_reads;
    logic [31:0] r_perf_writes;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_reads  <= '0;
            r_perf_writes <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_accept && !req_write) r_perf_reads  <= r_perf_reads + 32'd1;
            if (w_accept &&  req_write) r_perf_writes <= r_perf_writes + 32'd1;
            if (rsp_valid && !rsp_ready) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_reads        = r_perf_reads;
    assign perf_writes       = r_perf_writes;
    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=4, DEPTH_WORDS=1024).
module tb_mem_responder;

    localparam int unsigned LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_write;
`ifdef MEM_RESPONDER_PERF_EN
    logic [31:0] perf_reads;
    logic [31:0] perf_writes;
    logic [31:0] perf_stall_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mem_responder #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .DEPTH_WORDS (1024),
        .LATENCY     (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_write (rsp_write)
`ifdef MEM_RESPONDER_PERF_EN
        ,
        .perf_reads        (perf_reads),
        .perf_writes       (perf_writes),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and return once rsp_valid is seen; lat counts edges from acceptance.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic rw,
                       output int lat);
        int g;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        req_valid = 1'b1;
        g = 0;
        while (!req_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        rw = rsp_write;
    endtask

    // With rsp_ready high the handshake completes on the next edge.
    task automatic finish_rsp(input string tag);
        @(posedge clk); #1;
        chk({tag, "_done"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        rw;
    int          lat;
    int          acc[3];
    int          na;
    int          seen;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_write", {31'd0, rsp_write}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready_before_edge", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

        // Store then read
        txn(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, rd, rw, lat);
        chk("st40_lat", 32'(lat), LAT);
        chk("st40_rdata", rd, 32'd0);
        chk("st40_write", {31'd0, rw}, 32'd1);
        finish_rsp("st40");
        txn(1'b0, 32'h40, 32'h0, 4'h0, rd, rw, lat);
        chk("rd40_lat", 32'(lat), LAT);
        chk("rd40_rdata", rd, 32'hDEADBEEF);
        chk("rd40_write", {31'd0, rw}, 32'd0);
        finish_rsp("rd40");

        // Byte enables
        txn(1'b1, 32'h80, 32'h11223344, 4'hF, rd, rw, lat);
        finish_rsp("st80a");
        txn(1'b1, 32'h80, 32'hAABBCCDD, 4'b0101, rd, rw, lat);
        finish_rsp("st80b");
        txn(1'b0, 32'h80, 32'h0, 4'h0, rd, rw, lat);
        chk("rd80_rdata", rd, 32'h11BB33DD);
        finish_rsp("rd80");

        // Address wrap and ignored byte offset
        txn(1'b1, 32'h1004, 32'h5A5A5A5A, 4'hF, rd, rw, lat);
        finish_rsp("st1004");
        txn(1'b0, 32'h0004, 32'h0, 4'h0, rd, rw, lat);
        chk("rd0004_rdata", rd, 32'h5A5A5A5A);
        finish_rsp("rd0004");
        txn(1'b0, 32'h0007, 32'h0, 4'h0, rd, rw, lat);
        chk("rd0007_rdata", rd, 32'h5A5A5A5A);
        finish_rsp("rd0007");

        // Backpressure: 7 cycles of rsp_ready low while in RESP
        rsp_ready = 1'b0;
        txn(1'b0, 32'h80, 32'h0, 4'h0, rd, rw, lat);
        chk("bp_first_rdata", rd, 32'h11BB33DD);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata", rsp_rdata, 32'h11BB33DD);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        finish_rsp("bp");

        // Back-to-back reads: wait LAT, one handshake cycle, one IDLE accept cycle
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h40;
        na = 0;
        for (int cyc = 0; cyc < 60 && na < 3; cyc++) begin
            if (req_ready) begin
                acc[na] = cyc;
                na++;
            end
            @(posedge clk); #1;
            if (na == 3) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(na), 32'd3);
        chk("b2b_gap1", 32'(acc[1] - acc[0]), LAT + 2);
        chk("b2b_gap2", 32'(acc[2] - acc[1]), LAT + 2);
        repeat (LAT + 3) begin
            @(posedge clk); #1;
        end
        chk("b2b_drained_valid", {31'd0, rsp_valid}, 32'd0);
        chk("b2b_drained_ready", {31'd0, req_ready}, 32'd1);

`ifdef MEM_RESPONDER_PERF_EN
        chk("perf_reads", perf_reads, 32'd8);
        chk("perf_writes", perf_writes, 32'd4);
        chk("perf_stall", perf_stall_cycles, 32'd7);
`endif

        // Reset in the middle of a read's WAIT phase
        req_write = 1'b0;
        req_addr  = 32'h80;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("mid_rst_rsp_write", {31'd0, rsp_write}, 32'd0);
`ifdef MEM_RESPONDER_PERF_EN
        chk("mid_rst_perf_reads", perf_reads, 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel_req_ready", {31'd0, req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        chk("no_stale_rsp", 32'(seen), 32'd0);

        // Array survives reset
        txn(1'b0, 32'h40, 32'h0, 4'h0, rd, rw, lat);
        chk("post_rst_lat", 32'(lat), LAT);
        chk("post_rst_rdata", rd, 32'hDEADBEEF);
        finish_rsp("post_rst");
`ifdef MEM_RESPONDER_PERF_EN
        chk("post_rst_perf_reads", perf_reads, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
